// File: rtl/mac_pkg.sv
// Shared definitions for the Dadda/Brent-Kung MAC family.
//   acc_w()    accumulator width from operand width and guard bits
//   LATENCY    sample edge to out_valid, in clocks
//   sat_max()  / sat_min(): clamp limits, returned in a wide vector;
//              callers keep the low ACC_W bits.
package mac_pkg;

  localparam int LATENCY = 2;
  localparam int SAT_W   = 256;

  function automatic int acc_w(input int n, input int guard);
    return 2 * n + guard;
  endfunction

  function automatic logic [SAT_W-1:0] sat_max(input int w, input bit sgn);
    logic [SAT_W-1:0] r;
    r = '0;
    for (int i = 0; i < SAT_W; i++)
      if (i < w) r[i] = 1'b1;
    if (sgn) r[w-1] = 1'b0;
    return r;
  endfunction

  function automatic logic [SAT_W-1:0] sat_min(input int w, input bit sgn);
    logic [SAT_W-1:0] r;
    r = '0;
    if (sgn) r[w-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/dadda_bk_mac_pipe_mult.sv
// Combinational multiplier and prefix adder used by the MAC.
//   bk_add     : W-bit Brent-Kung adder, x + y + ci -> sum (carry-out is
//                recovered by the caller from an extra top bit).
//   dadda_mult : N x N -> 2N product. Partial products are compressed by a
//                Dadda tree to two rows, then summed with bk_add.
//                SIGNED=1 uses Baugh-Wooley (inverted cross terms plus
//                constant ones at columns N and 2N-1).
module bk_add #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] sum
);
  localparam int LG = $clog2(W);

  always_comb begin : prefix
    logic [W-1:0] p, g, gg, pp;
    p  = x ^ y;
    g  = x & y;
    gg = g;
    pp = p;
    // fold carry-in into bit 0 so every prefix includes it
    gg[0] = g[0] | (p[0] & ci);
    // up-sweep: spans of 2^(l+1) ending at i
    for (int l = 0; l < LG; l++)
      for (int i = 0; i < W; i++)
        if (((i + 1) % (1 << (l + 1))) == 0) begin
          gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
          pp[i] = pp[i] & pp[i - (1 << l)];
        end
    // down-sweep: fill remaining positions from the nearest complete prefix
    for (int l = LG; l >= 1; l--)
      for (int i = 0; i < W; i++)
        if ((((i + 1) % (1 << l)) == (1 << (l - 1))) && (i >= (1 << l)))
          gg[i] = gg[i] | (pp[i] & gg[i - (1 << (l - 1))]);
    if (W > 1) sum = p ^ {gg[W-2:0], ci};
    else       sum = p ^ {ci};
  end
endmodule

module dadda_mult #(
  parameter int N      = 8,
  parameter int SIGNED = 0
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);
  localparam int W2   = 2 * N;
  localparam int MAXH = N + 2;
  localparam int NSTG = 12;   // Dadda heights 2,3,4,6,9,... cover well past any N used

  logic [W2-1:0] row_x, row_y;

  always_comb begin : reduce
    logic [MAXH-1:0] cur  [W2];
    logic [MAXH-1:0] nxt  [W2];
    int              cnt  [W2];
    int              ncnt [W2];
    int              dseq [NSTG];
    int              d, r, q;
    logic            s, c, pb;
    s = 1'b0; c = 1'b0; pb = 1'b0; d = 0; r = 0; q = 0;
    for (int j = 0; j < W2; j++) begin
      cur[j] = '0; nxt[j] = '0; cnt[j] = 0; ncnt[j] = 0;
    end
    // partial-product matrix
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        pb = a[i] & b[j];
        if ((SIGNED != 0) && ((i == N - 1) != (j == N - 1))) pb = ~pb;
        cur[i+j][cnt[i+j]] = pb;
        cnt[i+j]++;
      end
    if (SIGNED != 0) begin
      cur[N][cnt[N]] = 1'b1;           cnt[N]++;
      cur[W2-1][cnt[W2-1]] = 1'b1;     cnt[W2-1]++;
    end
    dseq[0] = 2;
    for (int k = 1; k < NSTG; k++) dseq[k] = (dseq[k-1] * 3) / 2;
    // stages with a target above the current height just copy through
    for (int st = NSTG - 1; st >= 0; st--) begin
      d = dseq[st];
      for (int j = 0; j < W2; j++) begin
        nxt[j] = '0; ncnt[j] = 0;
      end
      for (int j = 0; j < W2; j++) begin
        q = 0;
        for (int k = 0; k < MAXH; k++) begin
          // r counts what column j would hold next stage if left alone
          r = cnt[j] - q + ncnt[j];
          if ((r > d) && (cnt[j] - q >= 2)) begin
            if ((r == d + 1) || (cnt[j] - q == 2)) begin
              s = cur[j][q] ^ cur[j][q+1];
              c = cur[j][q] & cur[j][q+1];
              q += 2;
            end else begin
              s = cur[j][q] ^ cur[j][q+1] ^ cur[j][q+2];
              c = (cur[j][q] & cur[j][q+1]) | (cur[j][q+2] & (cur[j][q] ^ cur[j][q+1]));
              q += 3;
            end
            nxt[j][ncnt[j]] = s;
            ncnt[j]++;
            // carries out of the top column are beyond 2N bits
            if (j < W2 - 1) begin
              nxt[j+1][ncnt[j+1]] = c;
              ncnt[j+1]++;
            end
          end
        end
        for (int k = 0; k < MAXH; k++)
          if ((k >= q) && (k < cnt[j])) begin
            nxt[j][ncnt[j]] = cur[j][k];
            ncnt[j]++;
          end
      end
      for (int j = 0; j < W2; j++) begin
        cur[j] = nxt[j]; cnt[j] = ncnt[j];
      end
    end
    for (int j = 0; j < W2; j++) begin
      row_x[j] = (cnt[j] > 0) ? cur[j][0] : 1'b0;
      row_y[j] = (cnt[j] > 1) ? cur[j][1] : 1'b0;
    end
  end

  // product is taken modulo 2^(2N); Baugh-Wooley relies on that wrap
  bk_add #(.W(W2)) u_final (.x(row_x), .y(row_y), .ci(1'b0), .sum(p));
endmodule

// File: rtl/dadda_bk_mac_pipe.sv
// Pipelined multiply-accumulate: acc <= (clr ? 0 : acc) + a*b + cin.
//   clk, rst (sync, active-high)
//   in_valid, a, b, cin, acc_clr : sample, taken on a rising edge with in_valid
//   out [ACC_W]                  : accumulator
//   out_valid                    : out was updated by a sample this cycle
//   cout                         : carry (unsigned) / signed overflow of that sample
//   ovf                          : sticky overflow, cleared by rst or an accepted acc_clr
// Stage 1 registers the product; stage 2 accumulates. Latency 2, one sample/clock.
import mac_pkg::*;

module dadda_bk_mac_pipe #(
  parameter  int N        = 8,
  parameter  int GUARD    = 8,
  parameter  int SIGNED   = 0,
  parameter  int SATURATE = 0,
  localparam int ACC_W    = acc_w(N, GUARD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             cin,
  input  logic             acc_clr,
  output logic [ACC_W-1:0] out,
  output logic             out_valid,
  output logic             cout,
  output logic             ovf
);
  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W, SIGNED != 0));
  localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W, SIGNED != 0));

  typedef struct packed {
    logic [2*N-1:0] prod;
    logic           cin;
    logic           clr;
  } s1_t;

  logic [2*N-1:0]     prod;
  s1_t                s1;
  logic [LATENCY-1:0] vld_pipe;   // [0]: stage-1 valid, [LATENCY-1]: out_valid
  logic [ACC_W:0]     base_x, prod_x, sum;
  logic               ovf_now;
  logic [ACC_W-1:0]   acc_nxt;

  dadda_mult #(.N(N), .SIGNED(SIGNED)) u_mult (.a(a), .b(b), .p(prod));

  // operands extended one bit past ACC_W so the carry/sign survives
  always_comb begin
    base_x = '0;
    if (!s1.clr) base_x = {((SIGNED != 0) ? out[ACC_W-1] : 1'b0), out};
    prod_x = {{(GUARD + 1){(SIGNED != 0) ? s1.prod[2*N-1] : 1'b0}}, s1.prod};
  end

  bk_add #(.W(ACC_W + 1)) u_acc (.x(base_x), .y(prod_x), .ci(s1.cin), .sum(sum));

  always_comb begin
    // signed: top two bits disagree when the true value left ACC_W range
    ovf_now = (SIGNED != 0) ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];
    acc_nxt = sum[ACC_W-1:0];
    if ((SATURATE != 0) && ovf_now) begin
      if ((SIGNED != 0) && sum[ACC_W]) acc_nxt = SAT_MIN;
      else                             acc_nxt = SAT_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1       <= '0;
      out      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[LATENCY-2:0], in_valid};
      if (in_valid) s1 <= '{prod: prod, cin: cin, clr: acc_clr};
      if (vld_pipe[0]) begin
        out  <= acc_nxt;
        cout <= ovf_now;
        ovf  <= (ovf & ~s1.clr) | ovf_now;
      end else begin
        cout <= 1'b0;
      end
    end
  end

  assign out_valid = vld_pipe[LATENCY-1];
endmodule

// File: tb/tb_dadda_bk_mac_pipe.sv
module tb_dadda_bk_mac_pipe;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0, acc_clr = 1'b0;

  logic [23:0] out0, out3;
  logic [15:0] out1, out2;
  logic        ov0, ov1, ov2, ov3;
  logic        co0, co1, co2, co3;
  logic        of0, of1, of2, of3;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  dadda_bk_mac_pipe u_base (.clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
    .acc_clr(acc_clr), .out(out0), .out_valid(ov0), .cout(co0), .ovf(of0));
  dadda_bk_mac_pipe #(.GUARD(0)) u_wrap (.clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .cin(cin), .acc_clr(acc_clr), .out(out1), .out_valid(ov1), .cout(co1), .ovf(of1));
  dadda_bk_mac_pipe #(.GUARD(0), .SATURATE(1)) u_sat (.clk(clk), .rst(rst), .in_valid(in_valid),
    .a(a), .b(b), .cin(cin), .acc_clr(acc_clr), .out(out2), .out_valid(ov2), .cout(co2), .ovf(of2));
  dadda_bk_mac_pipe #(.SIGNED(1)) u_sgn (.clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .cin(cin), .acc_clr(acc_clr), .out(out3), .out_valid(ov3), .cout(co3), .ovf(of3));

  // inputs change 1 time unit after a rising edge, outputs are read there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] va, input logic [7:0] vb,
                       input logic vc, input logic vclr);
    in_valid = v; a = va; b = vb; cin = vc; acc_clr = vclr;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    tick(); tick();
    ncmp++; if (out0 !== 24'd0) begin nerr++; $display("FAIL reset_out got %0d want 0", out0); end
    ncmp++; if (ov0 !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b want 0", ov0); end
    ncmp++; if (co0 !== 1'b0 || of0 !== 1'b0) begin nerr++; $display("FAIL reset_flags got cout=%b ovf=%b want 0/0", co0, of0); end
    ncmp++; if (out3 !== 24'd0) begin nerr++; $display("FAIL reset_out_signed got %h want 0", out3); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    drive(1'b1, 8'd15, 8'd15, 1'b0, 1'b1);
    tick();
    drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    ncmp++; if (ov0 !== 1'b0) begin nerr++; $display("FAIL basic_early_valid got %b want 0", ov0); end
    tick();
    ncmp++; if (out0 !== 24'd225) begin nerr++; $display("FAIL basic_225 got %0d want 225", out0); end
    ncmp++; if (ov0 !== 1'b1) begin nerr++; $display("FAIL basic_valid got %b want 1", ov0); end
    tick();
    ncmp++; if (ov0 !== 1'b0 || out0 !== 24'd225) begin nerr++; $display("FAIL basic_hold got valid=%b out=%0d want 0/225", ov0, out0); end
    drive(1'b1, 8'd3, 8'd4, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    tick();
    ncmp++; if (out0 !== 24'd238 || ov0 !== 1'b1) begin nerr++; $display("FAIL basic_cin got out=%0d valid=%b want 238/1", out0, ov0); end
    // acc_clr without in_valid must not disturb the accumulator
    drive(1'b0, 8'd5, 8'd5, 1'b0, 1'b1);
    tick();
    drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    tick();
    ncmp++; if (out0 !== 24'd238 || ov0 !== 1'b0) begin nerr++; $display("FAIL clr_no_valid got out=%0d valid=%b want 238/0", out0, ov0); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 8'd255, 8'd255, 1'b0, 1'b1);
    tick();
    drive(1'b1, 8'd255, 8'd255, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'd255, 8'd255, 1'b0, 1'b0);
    ncmp++; if (out0 !== 24'd65025 || ov0 !== 1'b1) begin nerr++; $display("FAIL b2b_1 got out=%0d valid=%b want 65025/1", out0, ov0); end
    tick();
    drive(1'b1, 8'd0, 8'd127, 1'b0, 1'b0);
    ncmp++; if (out0 !== 24'd130050 || ov0 !== 1'b1) begin nerr++; $display("FAIL b2b_2 got out=%0d valid=%b want 130050/1", out0, ov0); end
    tick();
    drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    ncmp++; if (out0 !== 24'd195075 || ov0 !== 1'b1) begin nerr++; $display("FAIL b2b_3 got out=%0d valid=%b want 195075/1", out0, ov0); end
    tick();
    ncmp++; if (out0 !== 24'd195075 || ov0 !== 1'b1) begin nerr++; $display("FAIL b2b_zero got out=%0d valid=%b want 195075/1", out0, ov0); end
    ncmp++; if (of0 !== 1'b0) begin nerr++; $display("FAIL b2b_ovf got %b want 0", of0); end
  endtask

  task automatic test_guard0();
    drive(1'b1, 8'd255, 8'd255, 1'b0, 1'b1);
    tick();
    drive(1'b1, 8'd255, 8'd255, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    ncmp++; if (out1 !== 16'd65025 || co1 !== 1'b0 || of1 !== 1'b0) begin nerr++; $display("FAIL wrap_first got out=%h cout=%b ovf=%b want fe01/0/0", out1, co1, of1); end
    ncmp++; if (out2 !== 16'd65025 || co2 !== 1'b0) begin nerr++; $display("FAIL sat_first got out=%h cout=%b want fe01/0", out2, co2); end
    tick();
    ncmp++; if (out1 !== 16'hFC02 || co1 !== 1'b1 || of1 !== 1'b1) begin nerr++; $display("FAIL wrap_ovf got out=%h cout=%b ovf=%b want fc02/1/1", out1, co1, of1); end
    ncmp++; if (out2 !== 16'hFFFF || co2 !== 1'b1 || of2 !== 1'b1) begin nerr++; $display("FAIL sat_ovf got out=%h cout=%b ovf=%b want ffff/1/1", out2, co2, of2); end
    tick();
    ncmp++; if (co1 !== 1'b0 || of1 !== 1'b1 || out1 !== 16'hFC02) begin nerr++; $display("FAIL wrap_bubble got out=%h cout=%b ovf=%b want fc02/0/1", out1, co1, of1); end
    ncmp++; if (co2 !== 1'b0 || of2 !== 1'b1 || out2 !== 16'hFFFF) begin nerr++; $display("FAIL sat_sticky got out=%h cout=%b ovf=%b want ffff/0/1", out2, co2, of2); end
    drive(1'b1, 8'd1, 8'd1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    tick();
    ncmp++; if (out1 !== 16'd1 || of1 !== 1'b0 || co1 !== 1'b0) begin nerr++; $display("FAIL wrap_clr got out=%h ovf=%b cout=%b want 1/0/0", out1, of1, co1); end
    ncmp++; if (out2 !== 16'd1 || of2 !== 1'b0) begin nerr++; $display("FAIL sat_clr got out=%h ovf=%b want 1/0", out2, of2); end
  endtask

  task automatic test_signed();
    drive(1'b1, 8'h80, 8'h7F, 1'b0, 1'b1);
    tick();
    drive(1'b1, 8'h80, 8'h80, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    ncmp++; if (out3 !== 24'hFFC080 || co3 !== 1'b0) begin nerr++; $display("FAIL signed_neg got out=%h cout=%b want ffc080/0", out3, co3); end
    tick();
    // -16256 + 16384 = 128
    ncmp++; if (out3 !== 24'h000080 || co3 !== 1'b0 || of3 !== 1'b0) begin nerr++; $display("FAIL signed_minsq got out=%h cout=%b ovf=%b want 000080/0/0", out3, co3, of3); end
  endtask

  task automatic test_rst_mid();
    drive(1'b1, 8'd100, 8'd100, 1'b0, 1'b1);
    tick();
    drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    ncmp++; if (ov0 !== 1'b0 || out0 !== 24'd0 || of0 !== 1'b0) begin nerr++; $display("FAIL rst_mid got valid=%b out=%0d ovf=%b want 0/0/0", ov0, out0, of0); end
    rst = 1'b0;
    tick();
    ncmp++; if (ov0 !== 1'b0 || out0 !== 24'd0) begin nerr++; $display("FAIL rst_mid_flush got valid=%b out=%0d want 0/0", ov0, out0); end
    tick();
    ncmp++; if (ov0 !== 1'b0) begin nerr++; $display("FAIL rst_mid_late got valid=%b want 0", ov0); end
    drive(1'b1, 8'd100, 8'd100, 1'b0, 1'b1);
    tick();
    drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    tick();
    ncmp++; if (out0 !== 24'd10000 || ov0 !== 1'b1) begin nerr++; $display("FAIL rst_mid_after got out=%0d valid=%b want 10000/1", out0, ov0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_guard0();
    test_signed();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
